// File: rtl/mips_io_pkg.sv
// Shared definitions for the MIPS host I/O bridge: default sizes,
// the TX holding-register state encoding and a pointer-width helper.
package mips_io_pkg;

  localparam int unsigned DATA_W_DEF   = 16;
  localparam int unsigned RX_DEPTH_DEF = 4;

  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_t;

  // Index width for a power-of-two buffer; a depth below 2 still gets one bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is visible on
// rd_data whenever the FIFO holds data and reads as zero when it is empty.
// A push while full and a pop while empty are both ignored.
module io_sync_fifo
  import mips_io_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = RX_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem[rd_ptr_q];

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + CW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/mips_io_bridge.sv
// Host-side end of the MIPS core I/O port. Host words are queued in an RX
// FIFO and presented on data_in; core writes are captured in a single-entry
// TX holding register and offered to the host via valid/ready.
// Build option: define MIPS_IO_OVF_IRQ_EN to also raise interrupt while
// tx_overflow is set.
module mips_io_bridge
  import mips_io_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned RX_DEPTH = RX_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_W-1:0]           host_rx_data,
  input  logic                        host_rx_valid,
  output logic                        host_rx_ready,
  output logic [DATA_W-1:0]           data_in,
  output logic                        interrupt,
  input  logic                        in_ack,
  input  logic [DATA_W-1:0]           data_out,
  input  logic                        out_strobe,
  output logic [DATA_W-1:0]           host_tx_data,
  output logic                        host_tx_valid,
  input  logic                        host_tx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        tx_overflow,
  input  logic                        ovf_clear
);

  logic              rx_full;
  logic              rx_empty;
  logic              rx_push;

  tx_state_t         tx_state_q;
  tx_state_t         tx_state_d;
  logic [DATA_W-1:0] tx_data_q;
  logic [DATA_W-1:0] tx_data_d;
  logic              tx_drop;
  logic              ovf_q;

  // Ready is forced low during reset so a host word presented then is not taken.
  assign host_rx_ready = !rx_full && !reset;
  assign rx_push       = host_rx_valid && host_rx_ready;

  io_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (RX_DEPTH)
  ) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (rx_push),
    .wr_data (host_rx_data),
    .pop     (in_ack),
    .rd_data (data_in),
    .full    (rx_full),
    .empty   (rx_empty),
    .count   (rx_count)
  );

  // TX holding register state and data.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_EMPTY;
      tx_data_q  <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // TX next state: capture on strobe unless a full register is not being drained.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_drop    = 1'b0;
    case (tx_state_q)
      TX_EMPTY: begin
        if (out_strobe) begin
          tx_data_d  = data_out;
          tx_state_d = TX_FULL;
        end
      end
      TX_FULL: begin
        if (out_strobe && host_tx_ready) begin
          tx_data_d = data_out;
        end else if (out_strobe) begin
          tx_drop = 1'b1;
        end else if (host_tx_ready) begin
          tx_state_d = TX_EMPTY;
        end
      end
      default: tx_state_d = TX_EMPTY;
    endcase
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (tx_drop) begin
      ovf_q <= 1'b1;
    end else if (ovf_clear) begin
      ovf_q <= 1'b0;
    end
  end

  assign host_tx_valid = (tx_state_q == TX_FULL);
  assign host_tx_data  = tx_data_q;
  assign tx_overflow   = ovf_q;

`ifdef MIPS_IO_OVF_IRQ_EN
  assign interrupt = !rx_empty || ovf_q;
`else
  assign interrupt = !rx_empty;
`endif

endmodule

// File: tb/tb_mips_io_bridge.sv
// Directed self-checking bench for mips_io_bridge. Inputs change 1 ns after
// the rising edge and are sampled by the following edge; outputs are checked
// 1 ns after the edge that should have produced them.
module tb_mips_io_bridge;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] host_rx_data;
  logic          host_rx_valid;
  logic          host_rx_ready;
  logic [DW-1:0] data_in;
  logic          interrupt;
  logic          in_ack;
  logic [DW-1:0] data_out;
  logic          out_strobe;
  logic [DW-1:0] host_tx_data;
  logic          host_tx_valid;
  logic          host_tx_ready;
  logic [2:0]    rx_count;
  logic          tx_overflow;
  logic          ovf_clear;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MIPS_IO_OVF_IRQ_EN
  localparam logic OVF_IRQ = 1'b1;
`else
  localparam logic OVF_IRQ = 1'b0;
`endif

  mips_io_bridge dut (
    .clk           (clk),
    .reset         (reset),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .data_in       (data_in),
    .interrupt     (interrupt),
    .in_ack        (in_ack),
    .data_out      (data_out),
    .out_strobe    (out_strobe),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .rx_count      (rx_count),
    .tx_overflow   (tx_overflow),
    .ovf_clear     (ovf_clear)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    host_rx_data  = w;
    host_rx_valid = 1'b1;
    tick();
    host_rx_valid = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [DW-1:0] w);
    check_val(tag, data_in, w);
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] fill_words [4];
    fill_words[0] = 16'h0001; fill_words[1] = 16'h0002;
    fill_words[2] = 16'h0003; fill_words[3] = 16'h0004;

    reset = 1'b1; host_rx_data = '0; host_rx_valid = 1'b0; in_ack = 1'b0;
    data_out = '0; out_strobe = 1'b0; host_tx_ready = 1'b0; ovf_clear = 1'b0;
    #1;

    // Reset: two cycles held, a host word offered during the second
    tick();
    host_rx_data = 16'hDEAD; host_rx_valid = 1'b1;
    check_val("rst_rx_ready", host_rx_ready, 0);
    tick();
    host_rx_valid = 1'b0;
    check_val("rst_rx_count", rx_count, 0);
    check_val("rst_data_in", data_in, 0);
    check_val("rst_irq", interrupt, 0);
    check_val("rst_tx_valid", host_tx_valid, 0);
    check_val("rst_tx_data", host_tx_data, 0);
    check_val("rst_ovf", tx_overflow, 0);
    reset = 1'b0;
    #1;
    check_val("rel_rx_ready", host_rx_ready, 1);
    check_val("rel_irq", interrupt, 0);
    tick();
    check_val("rel_no_push", rx_count, 0);

    // RX single word
    push_word(16'hA5A5);
    check_val("single_data", data_in, 16'hA5A5);
    check_val("single_irq", interrupt, 1);
    check_val("single_count", rx_count, 1);
    pop_expect("single_pop", 16'hA5A5);
    check_val("single_empty_data", data_in, 0);
    check_val("single_empty_irq", interrupt, 0);

    // in_ack while empty is ignored
    in_ack = 1'b1; tick(); in_ack = 1'b0;
    check_val("ack_empty_count", rx_count, 0);
    push_word(16'h0042);
    check_val("ack_empty_then_push", rx_count, 1);
    pop_expect("ack_empty_pop", 16'h0042);

    // Fill, refuse a fifth word, pop, then accept it across the wrap
    for (int i = 0; i < 4; i++) push_word(fill_words[i]);
    check_val("fill_count", rx_count, 4);
    check_val("fill_ready", host_rx_ready, 0);
    host_rx_data = 16'h0005; host_rx_valid = 1'b1;
    tick();
    check_val("fill_refuse_count", rx_count, 4);
    check_val("fill_head", data_in, 16'h0001);
    in_ack = 1'b1;
    tick();
    in_ack = 1'b0;
    check_val("fill_pop_count", rx_count, 3);
    check_val("fill_pop_ready", host_rx_ready, 1);
    tick();
    host_rx_valid = 1'b0;
    check_val("fill_wrap_count", rx_count, 4);
    pop_expect("wrap_pop2", 16'h0002);
    pop_expect("wrap_pop3", 16'h0003);
    pop_expect("wrap_pop4", 16'h0004);
    pop_expect("wrap_pop5", 16'h0005);
    check_val("wrap_drained", rx_count, 0);

    // Simultaneous push and pop at count 2
    push_word(16'h0011);
    push_word(16'h0022);
    check_val("sim_pre_count", rx_count, 2);
    host_rx_data = 16'h0BEE; host_rx_valid = 1'b1; in_ack = 1'b1;
    tick();
    host_rx_valid = 1'b0; in_ack = 1'b0;
    check_val("sim_count", rx_count, 2);
    pop_expect("sim_pop1", 16'h0022);
    pop_expect("sim_pop2", 16'h0BEE);
    check_val("sim_irq_off", interrupt, 0);

    // TX backpressure, drop and overflow, FIFO empty
    host_tx_ready = 1'b0;
    data_out = 16'h1234; out_strobe = 1'b1;
    tick();
    check_val("tx_valid", host_tx_valid, 1);
    check_val("tx_data", host_tx_data, 16'h1234);
    check_val("tx_no_ovf", tx_overflow, 0);
    check_val("tx_irq_clean", interrupt, 0);
    data_out = 16'h5678;
    tick();
    check_val("drop_data", host_tx_data, 16'h1234);
    check_val("drop_ovf", tx_overflow, 1);
    check_val("ovf_irq", interrupt, OVF_IRQ);
    data_out = 16'h9ABC; ovf_clear = 1'b1;
    tick();
    check_val("clr_drop_ovf", tx_overflow, 1);
    check_val("clr_drop_data", host_tx_data, 16'h1234);
    out_strobe = 1'b0;
    tick();
    ovf_clear = 1'b0;
    check_val("clr_ovf", tx_overflow, 0);
    check_val("clr_irq", interrupt, 0);
    check_val("clr_still_valid", host_tx_valid, 1);

    // Drain, then full-rate TX streaming
    host_tx_ready = 1'b1;
    tick();
    check_val("drain_valid", host_tx_valid, 0);
    data_out = 16'h1111; out_strobe = 1'b1;
    tick();
    check_val("stream1", host_tx_data, 16'h1111);
    data_out = 16'h2222;
    tick();
    check_val("stream2", host_tx_data, 16'h2222);
    check_val("stream_valid", host_tx_valid, 1);
    check_val("stream_no_ovf", tx_overflow, 0);
    out_strobe = 1'b0;
    tick();
    check_val("stream_done", host_tx_valid, 0);

    // Reset mid-operation flushes both paths
    push_word(16'h7777);
    host_tx_ready = 1'b0; data_out = 16'h3333; out_strobe = 1'b1;
    tick();
    out_strobe = 1'b0;
    reset = 1'b1; host_rx_data = 16'h4444; host_rx_valid = 1'b1;
    tick();
    reset = 1'b0; host_rx_valid = 1'b0;
    check_val("mid_rst_count", rx_count, 0);
    check_val("mid_rst_data_in", data_in, 0);
    check_val("mid_rst_tx_valid", host_tx_valid, 0);
    check_val("mid_rst_tx_data", host_tx_data, 0);
    tick();
    check_val("mid_rst_after", rx_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_io_bridge.md
# mips_io_bridge

- Word-level I/O bridge between the 16-bit MIPS core's `data_in` / `data_out` / `interrupt` pins and an external host.
- It is the host-side end of the core's I/O port:
  - Host words are buffered in an RX FIFO and presented on `data_in`.
  - `interrupt` is raised while input is pending.
  - Words the core writes on `data_out` are captured and handed to the host.
- Both host-side paths use valid/ready handshakes.

## Interface
Parameters:
- `DATA_W`, 16, word width; matches core datapath.
- `RX_DEPTH`, 4, RX FIFO entries; power of 2, at least 2.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `host_rx_data`  in  DATA_W  word from host.
- `host_rx_valid`  in  1  host word valid.
- `host_rx_ready`  out  1  bridge can accept a host word.
- `data_in`  out  DATA_W  head of RX FIFO, to core; 0 when empty.
- `interrupt`  out  1  to core; input pending (see Configuration).
- `in_ack`  in  1  core consumed `data_in`; one-cycle pulse, pops FIFO.
- `data_out`  in  DATA_W  word from core.
- `out_strobe`  in  1  core write qualifier for `data_out`.
- `host_tx_data`  out  DATA_W  word to host.
- `host_tx_valid`  out  1  `host_tx_data` valid.
- `host_tx_ready`  in  1  host accepts word.
- `rx_count`  out  $clog2(RX_DEPTH)+1  RX occupancy.
- `tx_overflow`  out  1  sticky: a core write was dropped.
- `ovf_clear`  in  1  clears `tx_overflow`.

## Operation
- **RX FIFO** (first-word fall-through):
  - Push when `host_rx_valid && host_rx_ready`.
  - `host_rx_ready = !full && !reset`.
  - Pop when `in_ack` and not empty. `in_ack` while empty is ignored, with no state change.
  - Push and pop in the same cycle leave `rx_count` unchanged.
  - When full, ready is 0, so a pop that cycle only frees a slot.
  - Pointers wrap modulo `RX_DEPTH`.
- **`data_in`**: equals the memory word at the read pointer when `rx_count != 0`, otherwise 16'h0000. Driven from registers only; no combinational path from host inputs.
- **TX holding register** (single entry, states EMPTY/FULL):
  - EMPTY + `out_strobe` → capture `data_out` → FULL.
  - FULL + `host_tx_ready` and no strobe → EMPTY.
  - FULL + `host_tx_ready` + `out_strobe` → capture the new word, stay FULL.
  - FULL + `out_strobe` without `host_tx_ready` → word dropped, `tx_overflow` set, held word unchanged.
- **`host_tx_valid`** is high exactly in FULL.
- **`tx_overflow`**: set on a drop, cleared by `ovf_clear`. Set and clear in the same cycle → stays 1.
- **`interrupt`**: level, `rx_count != 0` (plus overflow per Configuration). Never pulsed; the core clears it by draining the FIFO.

## Timing
- Reset values:
  - `rx_count` = 0, `data_in` = 0, `interrupt` = 0.
  - `host_tx_valid` = 0, `host_tx_data` = 0, `tx_overflow` = 0.
  - `host_rx_ready` = 0 while `reset` is high, 1 in the first cycle after.
- Reset mid-operation flushes the FIFO and the TX register. An in-flight host push during the reset cycle is not accepted.
- RX latency: push at edge N → `data_in` valid and `interrupt` high in cycle N+1.
- Pop at edge N → next word on `data_in` in cycle N+1. If that pop emptied the FIFO, `interrupt` falls in cycle N+1.
- TX latency: strobe at edge N → `host_tx_valid` high in cycle N+1.
- Full-rate streaming is sustained: one RX word and one TX word per cycle.

## Configuration
- `MIPS_IO_OVF_IRQ_EN` defined: `interrupt = (rx_count != 0) | tx_overflow`.
- Not defined: `interrupt = (rx_count != 0)`. `tx_overflow` is still reported on its port.

## Structure
- Shared package `mips_io_pkg` holds:
  - `DATA_W` default and `RX_DEPTH` default.
  - The TX state enum (`TX_EMPTY`, `TX_FULL`).
  - A pointer-width helper function.
- Sub-module `io_sync_fifo`: parameterised synchronous FWFT FIFO. It provides push/pop/full/empty/count and is instantiated once for RX.
- Top level contains the TX register, overflow flag and interrupt logic.

## Test plan
- **Reset release**:
  - Stimulus: hold `reset` 2 cycles, then release.
  - Response: all outputs 0 during reset; `host_rx_ready` = 1 in the first cycle after release; `interrupt` = 0.
- **RX single word**:
  - Stimulus: push 16'hA5A5.
  - Response: next cycle `data_in` = A5A5, `interrupt` = 1, `rx_count` = 1. After `in_ack`, `data_in` = 0, `interrupt` = 0.
- **RX fill/wrap**:
  - Stimulus: push 0x0001..0x0004; then hold valid with 0x0005; then pop once.
  - Response: after the four pushes, `host_rx_ready` = 0 and `rx_count` = 4, and 0x0005 is not accepted. The pop re-asserts ready; pop order is 1,2,3,4,5 across the pointer wrap.
- **Simultaneous push/pop**:
  - Stimulus: at `rx_count` = 2, push 0x0BEE and `in_ack` in the same cycle.
  - Response: `rx_count` stays 2; 0x0BEE pops last.
- **TX backpressure**:
  - Stimulus: strobe 0x1234 with `host_tx_ready` = 0, then strobe 0x5678.
  - Response: `host_tx_data` stays 0x1234 and `tx_overflow` = 1. Assert `ovf_clear` and strobe 0x9ABC in the same cycle, still with `host_tx_ready` = 0: `tx_overflow` remains 1.
- **Overflow IRQ**:
  - Stimulus: force a TX drop with the FIFO empty.
  - Response: with `MIPS_IO_OVF_IRQ_EN`, `interrupt` = 1 until `ovf_clear`. Without the macro, `interrupt` stays 0.
